// File: rtl/gnn_0_buf_arb_pkg.sv
// Shared definitions for the output-buffer bank read arbiters: default widths,
// tag sizing and the round-robin winner search.
package gnn_0_buf_arb_pkg;

  localparam int BUF_ADDR_WIDTH_DEF = 11;
  localparam int DATA_WIDTH_DEF     = 512;
  localparam int MAX_REQ            = 4;

  // Result of a round-robin search: whether anyone requested, and who won.
  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

  // Width of a requester tag; a single bit is kept even for one requester.
  function automatic int tag_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of valid[0..n-1], searching upward from ptr and wrapping.
  function automatic rr_pick_t rr_search(input logic [MAX_REQ-1:0] valid,
                                         input logic [1:0]         ptr,
                                         input int                 n);
    rr_pick_t   pick;
    logic [1:0] idx;
    pick = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = 2'((int'(ptr) + k) % n);
      if (k < n && !pick.found && valid[idx]) begin
        pick.found = 1'b1;
        pick.idx   = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/gnn_0_tag_fifo.sv
// Small synchronous FIFO holding requester tags of in-flight reads. Push and
// pop may happen in the same cycle; the head entry is visible combinationally.
module gnn_0_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Tag storage write.
  // NOTE: storage is deliberately not reset; an entry is only ever read after it has been written.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gnn_0_buf_rd_arb.sv
// Read-port arbiter for one output-buffer bank. Requesters are granted
// round-robin; a tag FIFO remembers who issued each in-flight read so the
// returned word is strobed back to the right requester.
module gnn_0_buf_rd_arb
  import gnn_0_buf_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int BUF_ADDR_WIDTH = BUF_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int MAX_OUT        = 8
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_REQ-1:0]                req_avalid,
  input  logic [NUM_REQ*BUF_ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_data,
  output logic                              bank_avalid,
  output logic [BUF_ADDR_WIDTH-1:0]         bank_addr,
  input  logic                              bank_valid,
  input  logic [DATA_WIDTH-1:0]             bank_data,
  output logic                              err_underflow
);

  localparam int TAG_W = tag_width(NUM_REQ);

  logic [TAG_W-1:0]          rr_ptr;
  logic                      ready_en;
  logic [MAX_REQ-1:0]        avalid_ext;
  logic [1:0]                ptr_ext;
  rr_pick_t                  pick;
  logic [TAG_W-1:0]          win;
  logic                      accept;
  logic [BUF_ADDR_WIDTH-1:0] sel_addr;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [TAG_W-1:0]          pop_tag;
  logic                      pop;

  // Round-robin winner on this cycle's requests; ready only from registered state.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    avalid_ext                = '0;
    avalid_ext[NUM_REQ-1:0]   = req_avalid;
    ptr_ext                   = '0;
    ptr_ext[TAG_W-1:0]        = rr_ptr;
    pick                      = rr_search(avalid_ext, ptr_ext, NUM_REQ);
    win                       = TAG_W'(pick.idx);
    accept                    = ready_en && !fifo_full && pick.found;
    req_ready                 = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  // Address of the winning requester.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == TAG_W'(i)) sel_addr = req_addr[i*BUF_ADDR_WIDTH +: BUF_ADDR_WIDTH];
    end
  end

  // A return is routed only if a read is actually outstanding.
  assign pop = bank_valid && !fifo_empty;

  gnn_0_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (accept),
    .push_data (win),
    .pop       (pop),
    .pop_data  (pop_tag),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Grant pointer and the one-cycle hold-off of ready after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr   <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) rr_ptr <= (win == TAG_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  // Registered bank request; the address holds when nothing is accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bank_avalid <= 1'b0;
      bank_addr   <= '0;
    end else begin
      bank_avalid <= accept;
      if (accept) bank_addr <= sel_addr;
    end
  end

  // Registered response routing and sticky underflow detection.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rsp_valid     <= '0;
      rsp_data      <= '0;
      err_underflow <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (pop) begin
        rsp_valid[pop_tag] <= 1'b1;
        rsp_data           <= bank_data;
      end
      if (bank_valid && fifo_empty) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gnn_0_buf_rd_arb.sv
// Self-checking bench for gnn_0_buf_rd_arb: randomized requesters and a bank
// model, compared every cycle against a queue-based reference model.
module tb_gnn_0_buf_rd_arb;

  localparam int N  = 2;
  localparam int AW = 11;
  localparam int DW = 512;
  localparam int MO = 8;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N-1:0]    req_avalid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            bank_avalid;
  logic [AW-1:0]   bank_addr;
  logic            bank_valid;
  logic [DW-1:0]   bank_data;
  logic            err_underflow;

  gnn_0_buf_rd_arb #(
    .NUM_REQ        (N),
    .BUF_ADDR_WIDTH (AW),
    .DATA_WIDTH     (DW),
    .MAX_OUT        (MO)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .req_avalid    (req_avalid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .bank_avalid   (bank_avalid),
    .bank_addr     (bank_addr),
    .bank_valid    (bank_valid),
    .bank_data     (bank_data),
    .err_underflow (err_underflow)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int            m_ptr = 0;
  int            m_out = 0;
  bit            m_en = 0;
  int            tag_q[$];
  logic          m_bank_avalid = 0;
  logic [AW-1:0] m_bank_addr = '0;
  logic [N-1:0]  m_rsp_valid = '0;
  logic [DW-1:0] m_rsp_data = '0;
  logic          m_err = 0;

  // Bank and requester environment.
  typedef struct {int addr; int due;} bank_req_t;
  bank_req_t bank_q[$];
  int  cyc = 0;
  int  lat = 3;
  bit  bank_stall = 0;
  bit  inject = 0;
  int  addr_q[N][$];
  bit  hold[N];
  int  prob[N];
  int  rx_cnt[N];
  int  exp_rx[N];
  int  gq[$];
  int  stall_acc = 0;
  int  bank_run = 0;
  int  max_run = 0;
  bit  want_first = 0;
  int  first_grant = -1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input int a);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = (32'(a) * 32'h9E3779B1) ^ (32'(k) << 20);
    return d;
  endfunction

  function automatic bit idle();
    bit r;
    r = (tag_q.size() == 0) && (bank_q.size() == 0) && (m_out == 0);
    for (int i = 0; i < N; i++) r = r && (addr_q[i].size() == 0) && !hold[i];
    return r;
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_out = 0; m_en = 0;
    tag_q.delete(); bank_q.delete();
    m_bank_avalid = 0; m_bank_addr = '0; m_rsp_valid = '0; m_rsp_data = '0; m_err = 0;
  endfunction

  // One clock cycle: drive at negedge, check, then advance the model at posedge.
  task automatic step();
    int           win;
    logic [N-1:0] exp_ready;
    @(negedge aclk);
    for (int i = 0; i < N; i++) begin
      if (!hold[i] && addr_q[i].size() > 0 && $urandom_range(99) < prob[i]) hold[i] = 1;
      req_avalid[i] = hold[i];
      req_addr[i*AW +: AW] = hold[i] ? AW'(addr_q[i][0]) : AW'($urandom);
    end
    bank_valid = 0;
    bank_data  = '0;
    if (inject) begin
      bank_valid = 1;
      bank_data  = data_of(999);
    end else if (!bank_stall && bank_q.size() > 0 && bank_q[0].due <= cyc) begin
      bank_valid = 1;
      bank_data  = data_of(bank_q[0].addr);
    end
    #1;
    win = -1;
    if (m_en && m_out < MO) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && hold[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    check("req_ready", DW'(req_ready), DW'(exp_ready));
    check("bank_avalid", DW'(bank_avalid), DW'(m_bank_avalid));
    check("bank_addr", DW'(bank_addr), DW'(m_bank_addr));
    check("rsp_valid", DW'(rsp_valid), DW'(m_rsp_valid));
    check("err_underflow", DW'(err_underflow), DW'(m_err));
    if (m_rsp_valid != '0) check("rsp_data", rsp_data, m_rsp_data);
    for (int i = 0; i < N; i++) begin
      if (rsp_valid[i]) rx_cnt[i]++;
      if (req_ready[i] && req_avalid[i]) begin
        gq.push_back(i);
        if (bank_stall) stall_acc++;
        if (want_first) begin
          first_grant = i;
          want_first  = 0;
        end
      end
    end
    bank_run = bank_avalid ? bank_run + 1 : 0;
    if (bank_run > max_run) max_run = bank_run;
    @(posedge aclk);
    if (!aresetn) begin
      m_en = 0;
    end else begin
      if (win >= 0) begin
        tag_q.push_back(win);
        m_bank_avalid = 1;
        m_bank_addr   = AW'(addr_q[win][0]);
        bank_q.push_back('{addr: addr_q[win][0], due: cyc + 1 + lat});
        void'(addr_q[win].pop_front());
        hold[win] = 0;
        m_ptr = (win + 1) % N;
        m_out++;
      end else begin
        m_bank_avalid = 0;
      end
      m_rsp_valid = '0;
      if (bank_valid) begin
        if (inject) inject = 0;
        else void'(bank_q.pop_front());
        if (tag_q.size() > 0) begin
          m_rsp_valid[tag_q.pop_front()] = 1'b1;
          m_rsp_data = bank_data;
          m_out--;
        end else begin
          m_err = 1;
        end
      end
      m_en = 1;
    end
    cyc++;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    bit done;
    n = 0;
    done = idle();
    while (!done && n < budget) begin
      step();
      n++;
      done = idle();
    end
    step();
    check({tag, "_drained"}, DW'(done), DW'(1));
  endtask

  task automatic load(input int r, input int a);
    addr_q[r].push_back(a);
    exp_rx[r]++;
  endtask

  task automatic check_rx(input string tag);
    for (int i = 0; i < N; i++) check($sformatf("%s_rx%0d", tag, i), DW'(rx_cnt[i]), DW'(exp_rx[i]));
  endtask

  initial begin
    req_avalid = '0; req_addr = '0; bank_valid = 0; bank_data = '0;
    for (int i = 0; i < N; i++) begin
      hold[i] = 0; prob[i] = 100; rx_cnt[i] = 0; exp_rx[i] = 0;
    end

    // Both requesters continuous from reset: alternation starting with 0.
    for (int a = 0; a < 8; a++) begin
      load(0, 16 + a);
      load(1, 100 + a);
    end
    repeat (3) step();
    check("rst_rsp_data", rsp_data, '0);
    #2 aresetn = 1;
    want_first = 1;
    drain("alt", 400);
    check("first_grant", DW'(first_grant), DW'(0));
    check("alt_seq", DW'(gq.size() >= 4 && gq[0] == 0 && gq[1] == 1 && gq[2] == 0 && gq[3] == 1), DW'(1));
    check_rx("alt");

    // Single requester streams 0..15 with bank latency 3.
    prob[1] = 0;
    lat = 3;
    max_run = 0;
    for (int a = 0; a < 16; a++) load(0, a);
    drain("stream", 400);
    check("stream_back_to_back", DW'(max_run), DW'(16));
    check_rx("stream");

    // Bank stalled 20 cycles: exactly MAX_OUT accepts, then one per pop.
    bank_stall = 1;
    stall_acc = 0;
    for (int a = 0; a < 12; a++) load(0, 200 + a);
    repeat (20) step();
    check("stall_accepts", DW'(stall_acc), DW'(MO));
    bank_stall = 0;
    drain("stall", 400);
    check_rx("stall");

    // Randomized traffic from both requesters with varying bank latency.
    for (int t = 0; t < 4; t++) begin
      lat = $urandom_range(1, 6);
      for (int i = 0; i < N; i++) begin
        prob[i] = $urandom_range(20, 100);
        for (int a = 0; a < 20; a++) load(i, $urandom_range(0, 2047));
      end
      drain($sformatf("rand%0d", t), 2000);
    end
    check_rx("rand");

    // Bank data with nothing outstanding.
    inject = 1;
    repeat (5) step();
    check("underflow_sticky", DW'(err_underflow), DW'(1));
    check("underflow_no_rsp", DW'(rx_cnt[0] + rx_cnt[1]), DW'(exp_rx[0] + exp_rx[1]));

    // Reset with 5 reads outstanding; rr_ptr sits at 1 beforehand.
    bank_stall = 1;
    prob[0] = 100;
    prob[1] = 0;
    for (int a = 0; a < 5; a++) addr_q[0].push_back(300 + a);
    repeat (7) step();
    @(negedge aclk);
    addr_q[0].push_back(400); addr_q[1].push_back(500);
    hold[0] = 1; hold[1] = 1;
    req_avalid = 2'b11;
    req_addr = {AW'(500), AW'(400)};
    #1 check("pre_reset_ready", DW'(req_ready), DW'(2'b10));
    #1 aresetn = 0;
    #1;
    check("rst_req_ready", DW'(req_ready), DW'(0));
    check("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    check("rst_rsp_data_mid", rsp_data, '0);
    check("rst_bank_avalid", DW'(bank_avalid), DW'(0));
    check("rst_bank_addr", DW'(bank_addr), DW'(0));
    check("rst_err_underflow", DW'(err_underflow), DW'(0));
    model_reset();
    bank_stall = 0;
    repeat (2) step();
    #2 aresetn = 1;
    want_first = 1;
    first_grant = -1;
    for (int i = 0; i < N; i++) begin
      rx_cnt[i] = 0;
      exp_rx[i] = 1;
    end
    drain("post_reset", 200);
    check("first_grant_after_reset", DW'(first_grant), DW'(0));
    check_rx("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
